pfxsum_seq: RTL and testbench
=============================

# pfxsum_seq

Sequencer for the `Pfxsum` datapath that computes an inclusive prefix sum over a multi-chunk array. Each chunk is V_LEN lanes of IWIDTH bits. For every chunk the block reads it from a synchronous source memory, issues it to `Pfxsum`, adds the running carry from earlier chunks to each lane, and writes the result to a destination memory. It sits between the memory subsystem and one `Pfxsum` instance and owns all of that instance's `valid_in` traffic.

## Interface
- `IWIDTH`, 8, lane width in bits.
- `V_LEN`, 8, lanes per chunk.
- `CHUNK_AW`, 2, chunk address width; maximum 2**CHUNK_AW chunks.
- `TIMEOUT`, 64, maximum cycles in WAIT before abort; must be ≥ 1.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request to begin a job; ignored unless IDLE.
- `num_chunks` in CHUNK_AW+1: chunk count, sampled when `start` is accepted.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at job end (normal or abort).
- `err` out 1: sticky timeout flag; cleared on the next accepted `start`.
- `rd_en` out 1: source read strobe.
- `rd_addr` out CHUNK_AW: source chunk index.
- `rd_data` in IWIDTH*V_LEN: source data, valid the cycle after `rd_en`.
- `pfx_valid_in` out 1: one-cycle issue pulse to `Pfxsum`.
- `pfx_ivec` out IWIDTH*V_LEN: chunk to `Pfxsum`; lane i is bits [i*IWIDTH +: IWIDTH].
- `pfx_valid_out` in 1: `Pfxsum` result strobe.
- `pfx_ovec` in IWIDTH*V_LEN: `Pfxsum` inclusive local prefix sum.
- `wr_en` out 1: destination write strobe.
- `wr_addr` out CHUNK_AW: destination chunk index, equal to the source index.
- `wr_data` out IWIDTH*V_LEN: carried result.

## Operation
- **States:** IDLE, READ, LATCH, ISSUE, WAIT, WRITE, DONE.
- **IDLE:**
  - On `start` with `num_chunks` = 0: clear `err`, go to DONE. No reads are made.
  - On `start` otherwise: latch the count, set the chunk index to 0, clear carry to 0, clear `err`, go to READ.
- **READ:** `rd_en`=1, `rd_addr`=index. Go to LATCH.
- **LATCH:** register `rd_data` into `ivec_r`. Go to ISSUE.
- **ISSUE:** `pfx_valid_in`=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - `pfx_ivec` always drives `ivec_r` and holds it stable until the next LATCH.
- **WAIT:**
  - On `pfx_valid_out`: register `wr_data` lane i = (`pfx_ovec` lane i + carry) mod 2**IWIDTH, then go to WRITE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without `pfx_valid_out`: set `err`, go to DONE.
  - If `pfx_valid_out` arrives in that same cycle, it wins: no error.
- **WRITE:**
  - `wr_en`=1, `wr_addr`=index. Carry ← `wr_data` lane V_LEN-1.
  - If index = count-1, go to DONE; else index+1, go to READ.
- **DONE:** `done`=1. Go to IDLE.
- **Arithmetic:** all lane arithmetic is IWIDTH bits and wraps silently. Carry is IWIDTH bits.
- **Ignored inputs:**
  - `start` while busy is ignored; the running job is not disturbed.
  - `pfx_valid_out` outside WAIT is ignored.
  - `num_chunks` > 2**CHUNK_AW is clamped to 2**CHUNK_AW.
- **Reset (any time, including mid-job):**
  - State returns to IDLE.
  - Index, carry, counter, `ivec_r` and `wr_data` are cleared to 0.
  - A `Pfxsum` result arriving after reset is ignored.

## Timing
- **Reset values:** `busy`, `done`, `err`, `rd_en`, `pfx_valid_in` and `wr_en` are 0. `rd_addr`, `wr_addr`, `pfx_ivec` and `wr_data` are 0.
- **Outputs:** all outputs are registered or decoded from state only; there is no combinational input→output path.
- **Per-chunk sequence:** `start` accepted at cycle T.
  - `rd_en` at T+1, LATCH at T+2, `pfx_valid_in` at T+3.
  - With `pfx_valid_out` at T+3+L (L ≥ 1), `wr_en` is at T+4+L.
  - The next chunk's `rd_en` is at T+5+L.
- **Per-chunk cost:** 4+L cycles.
- **Job end:** `done` is at the last WRITE cycle + 1. `busy` falls the cycle after `done`.
- **Zero-chunk job:** `start` with `num_chunks`=0 gives `done` at T+1 with no other strobes.
- **Timeout:** with no `pfx_valid_out`, `done` and `err` both assert at ISSUE + TIMEOUT + 1.
- **Issue limit:** at most one chunk is outstanding at `Pfxsum`. A new issue never occurs before the previous result is written.

## Test plan
- **Two chunks, no wrap.** Defaults; chunk 0 and chunk 1 each all 0x01; `num_chunks`=2.
  - Writes: addr 0 = 01,02,…,08 and addr 1 = 09,0A,…,10 (lane 0 first).
  - `done` one cycle after the second write; `err`=0.
- **Carry wrap.** Chunk 0 all 0xFF, chunk 1 all 0x01.
  - `Pfxsum` returns FF,FE,…,F8 for chunk 0. Writes: addr 0 = FF,FE,…,F8 and addr 1 = F9,FA,…,00.
- **Zero chunks and busy start.**
  - `start` with `num_chunks`=0 → `done` at T+1 with no `rd_en`, `pfx_valid_in` or `wr_en`.
  - `start` pulsed mid-job → ignored; the write sequence is unchanged.
- **Timeout.** Bench model never returns `pfx_valid_out`; TIMEOUT=64.
  - `err`=1 and `done` pulse 65 cycles after `pfx_valid_in`; no `wr_en`.
  - Next `start` clears `err`.
  - `pfx_valid_out` at exactly counter = TIMEOUT-1 → normal write, `err`=0.
- **Reset mid-WAIT.** Drop `rst_n` asynchronously during WAIT of chunk 1.
  - All outputs are 0 immediately.
  - A late `pfx_valid_out` produces no `wr_en`.
  - A fresh 1-chunk job then completes with carry 0.
- **Variable latency.** Random L in 1..20 over 4 chunks of random data.
  - Written data matches a reference running prefix sum mod 256.
  - Exactly one `pfx_valid_in` per chunk.

Source files
------------

// File: rtl/pfxsum_seq_if.sv
// Bus bundle between the prefix-sum sequencer, its source/destination memories and one Pfxsum datapath.
interface pfxsum_seq_if #(
  parameter int unsigned IWIDTH   = 8,
  parameter int unsigned V_LEN    = 8,
  parameter int unsigned CHUNK_AW = 2
);
  localparam int unsigned VW = IWIDTH * V_LEN;

  logic                start;
  logic [CHUNK_AW:0]   num_chunks;
  logic                busy;
  logic                done;
  logic                err;
  logic                rd_en;
  logic [CHUNK_AW-1:0] rd_addr;
  logic [VW-1:0]       rd_data;
  logic                pfx_valid_in;
  logic [VW-1:0]       pfx_ivec;
  logic                pfx_valid_out;
  logic [VW-1:0]       pfx_ovec;
  logic                wr_en;
  logic [CHUNK_AW-1:0] wr_addr;
  logic [VW-1:0]       wr_data;

  // Requester / memory / datapath side
  modport master (
    output start, num_chunks, rd_data, pfx_valid_out, pfx_ovec,
    input  busy, done, err, rd_en, rd_addr, pfx_valid_in, pfx_ivec,
           wr_en, wr_addr, wr_data
  );

  // Sequencer side
  modport slave (
    input  start, num_chunks, rd_data, pfx_valid_out, pfx_ovec,
    output busy, done, err, rd_en, rd_addr, pfx_valid_in, pfx_ivec,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pfxsum_seq.sv
// Chunk sequencer for Pfxsum: read chunk, issue it, add the running carry to the
// returned local prefix sum, write it back; one chunk outstanding at a time.
module pfxsum_seq #(
  parameter int unsigned IWIDTH   = 8,
  parameter int unsigned V_LEN    = 8,
  parameter int unsigned CHUNK_AW = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  pfxsum_seq_if.slave  bus
);

  localparam int unsigned VW = IWIDTH * V_LEN;
  localparam int unsigned NW = CHUNK_AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [NW-1:0] MAX_CHUNKS = NW'(1 << CHUNK_AW);
  localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t              r_state, w_state_nx;
  logic [CHUNK_AW-1:0] r_idx, w_idx_nx;
  logic [NW-1:0]       r_count, w_count_nx;
  logic [IWIDTH-1:0]   r_carry, w_carry_nx;
  logic [TW-1:0]       r_tmr, w_tmr_nx;
  logic [VW-1:0]       r_ivec, w_ivec_nx;
  logic [VW-1:0]       r_wdata, w_wdata_nx;
  logic                r_err, w_err_nx;
  logic [VW-1:0]       w_sum;
  logic                r_busy, r_done, r_rd_en, r_vin, r_wr_en;

  // Carry-adjusted lanes of the returned local prefix sum
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(V_LEN); i++) begin
      w_sum[i*IWIDTH +: IWIDTH] = bus.pfx_ovec[i*IWIDTH +: IWIDTH] + r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_count_nx = r_count;
    w_carry_nx = r_carry;
    w_tmr_nx   = r_tmr;
    w_ivec_nx  = r_ivec;
    w_wdata_nx = r_wdata;
    w_err_nx   = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_err_nx = 1'b0;
          if (bus.num_chunks == '0) begin
            w_state_nx = S_DONE;
          end else begin
            w_count_nx = (bus.num_chunks > MAX_CHUNKS) ? MAX_CHUNKS : bus.num_chunks;
            w_idx_nx   = '0;
            w_carry_nx = '0;
            w_state_nx = S_READ;
          end
        end
      end
      S_READ:  w_state_nx = S_LATCH;
      S_LATCH: begin
        w_ivec_nx  = bus.rd_data;
        w_state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        w_tmr_nx   = '0;
        w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        // A result on the final timeout cycle still wins over the abort
        if (bus.pfx_valid_out) begin
          w_wdata_nx = w_sum;
          w_state_nx = S_WRITE;
        end else if (r_tmr == T_LAST) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_DONE;
        end else begin
          w_tmr_nx = r_tmr + TW'(1);
        end
      end
      S_WRITE: begin
        w_carry_nx = r_wdata[VW-1 -: IWIDTH];
        if ({1'b0, r_idx} == r_count - NW'(1)) begin
          w_state_nx = S_DONE;
        end else begin
          w_idx_nx   = r_idx + CHUNK_AW'(1);
          w_state_nx = S_READ;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath registers; strobes are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_count <= '0;
      r_carry <= '0;
      r_tmr   <= '0;
      r_ivec  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_vin   <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_idx   <= w_idx_nx;
      r_count <= w_count_nx;
      r_carry <= w_carry_nx;
      r_tmr   <= w_tmr_nx;
      r_ivec  <= w_ivec_nx;
      r_wdata <= w_wdata_nx;
      r_err   <= w_err_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
      r_rd_en <= (w_state_nx == S_READ);
      r_vin   <= (w_state_nx == S_ISSUE);
      r_wr_en <= (w_state_nx == S_WRITE);
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.rd_en        = r_rd_en;
  assign bus.rd_addr      = r_idx;
  assign bus.pfx_valid_in = r_vin;
  assign bus.pfx_ivec     = r_ivec;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_idx;
  assign bus.wr_data      = r_wdata;

endmodule

// File: tb/tb_pfxsum_seq.sv
// Scoreboard bench for pfxsum_seq with a source memory and a variable-latency Pfxsum model.
module tb_pfxsum_seq;
  localparam int unsigned IWIDTH   = 8;
  localparam int unsigned V_LEN    = 8;
  localparam int unsigned CHUNK_AW = 2;
  localparam int unsigned TIMEOUT  = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pfxsum_seq_if #(.IWIDTH(IWIDTH), .V_LEN(V_LEN), .CHUNK_AW(CHUNK_AW)) bus ();

  pfxsum_seq #(.IWIDTH(IWIDTH), .V_LEN(V_LEN), .CHUNK_AW(CHUNK_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lpfx(input logic [63:0] v);
    logic [7:0]  s;
    logic [63:0] r;
    s = 8'h00;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + v[i*8 +: 8];
      r[i*8 +: 8] = s;
    end
    return r;
  endfunction

  // Source memory: synchronous read
  logic [63:0] src_mem [4];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr];

  // Pfxsum model: lat_cfg > 0 fixed latency, 0 never answers, < 0 random 1..20
  int          lat_cfg = 1;
  int          rem     = 0;
  logic [63:0] ovec_r  = '0;
  always @(posedge clk) begin
    if (rem > 0) rem <= rem - 1;
    if (bus.pfx_valid_in) begin
      ovec_r <= lpfx(bus.pfx_ivec);
      rem    <= (lat_cfg < 0) ? int'($urandom_range(20, 1)) : lat_cfg;
    end
  end
  assign bus.pfx_valid_out = (rem == 1);
  assign bus.pfx_ovec      = ovec_r;

  // Scoreboard of expected writes, built from a whole-array running prefix sum
  logic [1:0]  exp_addr [$];
  logic [63:0] exp_data [$];

  task automatic push_job(input int n);
    logic [7:0]  s;
    logic [63:0] d;
    logic [63:0] v;
    s = 8'h00;
    for (int c = 0; c < n; c++) begin
      v = src_mem[c];
      d = '0;
      for (int i = 0; i < 8; i++) begin
        s = s + v[i*8 +: 8];
        d[i*8 +: 8] = s;
      end
      exp_addr.push_back(2'(c));
      exp_data.push_back(d);
    end
  endtask

  // Monitor
  int          cyc = 0;
  int          rd_cnt, vin_cnt, wr_cnt, done_cyc;
  int          rd_c [8];
  int          vin_c [8];
  int          wr_c [8];
  bit          done_seen;
  logic        err_at_done, busy_at_done, err_after_start;
  logic [63:0] last_wd;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [1:0]  a;
    logic [63:0] d;
    if (bus.rd_en) begin
      if (rd_cnt < 8) rd_c[rd_cnt] = cyc;
      rd_cnt++;
    end
    if (bus.pfx_valid_in) begin
      if (vin_cnt < 8) vin_c[vin_cnt] = cyc;
      vin_cnt++;
    end
    if (bus.wr_en) begin
      if (wr_cnt < 8) wr_c[wr_cnt] = cyc;
      wr_cnt++;
      last_wd = bus.wr_data;
      if (exp_addr.size() == 0) begin
        chk("wr_unexpected", 64'd1, 64'd0);
      end else begin
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(a));
        chk("wr_data", bus.wr_data, d);
      end
    end
    if (bus.done) begin
      done_seen    = 1'b1;
      done_cyc     = cyc;
      err_at_done  = bus.err;
      busy_at_done = bus.busy;
    end
  end

  task automatic clear_mon();
    rd_cnt = 0; vin_cnt = 0; wr_cnt = 0; done_cyc = 0;
    done_seen = 1'b0; err_at_done = 1'b0; busy_at_done = 1'b0;
  endtask

  // Runs one job to completion; poke > 0 pulses a stray start that many cycles in
  task automatic run_job(input int n, input int lat, input int poke, output int t);
    lat_cfg = lat;
    clear_mon();
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.num_chunks = 3'(n);
    t = cyc;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.num_chunks  = '0;
    err_after_start = bus.err;
    for (int k = 0; k < 400 && !done_seen; k++) begin
      bus.start      = (poke > 0 && k == poke);
      bus.num_chunks = bus.start ? 3'd1 : 3'd0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("busy_at_done", 64'(busy_at_done), 64'd1);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("sb_drained", 64'(exp_addr.size()), 64'd0);
  endtask

  initial begin
    int t;
    int w0;
    bus.start      = 1'b0;
    bus.num_chunks = '0;
    for (int i = 0; i < 4; i++) src_mem[i] = '0;
    clear_mon();

    repeat (3) @(posedge clk); #1;
    chk("rst_strobes", 64'({bus.busy, bus.done, bus.err, bus.rd_en, bus.pfx_valid_in, bus.wr_en}), 64'd0);
    chk("rst_addr", 64'({bus.rd_addr, bus.wr_addr}), 64'd0);
    chk("rst_ivec", bus.pfx_ivec, 64'd0);
    chk("rst_wdata", bus.wr_data, 64'd0);
    rst_n = 1'b1;

    // Two chunks of 0x01, fixed latency 3
    src_mem[0] = 64'h0101010101010101;
    src_mem[1] = 64'h0101010101010101;
    push_job(2);
    run_job(2, 3, 0, t);
    chk("t1_rd0_cyc", 64'(rd_c[0]), 64'(t + 1));
    chk("t1_vin0_cyc", 64'(vin_c[0]), 64'(t + 3));
    chk("t1_wr0_cyc", 64'(wr_c[0]), 64'(t + 7));
    chk("t1_rd1_cyc", 64'(rd_c[1]), 64'(t + 8));
    chk("t1_done_cyc", 64'(done_cyc), 64'(wr_c[1] + 1));
    chk("t1_last_wd", last_wd, 64'h100F0E0D0C0B0A09);
    chk("t1_err", 64'(err_at_done), 64'd0);
    chk("t1_wr_cnt", 64'(wr_cnt), 64'd2);

    // Carry wrap
    src_mem[0] = 64'hFFFFFFFFFFFFFFFF;
    src_mem[1] = 64'h0101010101010101;
    push_job(2);
    run_job(2, 5, 0, t);
    chk("t2_last_wd", last_wd, 64'h00FFFEFDFCFBFAF9);
    chk("t2_err", 64'(err_at_done), 64'd0);

    // Zero-chunk job
    run_job(0, 1, 0, t);
    chk("t3_done_cyc", 64'(done_cyc), 64'(t + 1));
    chk("t3_strobes", 64'(rd_cnt + vin_cnt + wr_cnt), 64'd0);

    // Start pulsed while busy
    for (int i = 0; i < 3; i++) src_mem[i] = {$urandom, $urandom};
    push_job(3);
    run_job(3, 4, 6, t);
    chk("t4_wr_cnt", 64'(wr_cnt), 64'd3);
    chk("t4_vin_cnt", 64'(vin_cnt), 64'd3);

    // Timeout, then sticky err cleared by next start, then a result on the last cycle
    src_mem[0] = {$urandom, $urandom};
    run_job(1, 0, 0, t);
    chk("t5_to_gap", 64'(done_cyc - vin_c[0]), 64'(TIMEOUT + 1));
    chk("t5_err_at_done", 64'(err_at_done), 64'd1);
    chk("t5_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("t5_err_sticky", 64'(bus.err), 64'd1);
    push_job(1);
    run_job(1, int'(TIMEOUT), 0, t);
    chk("t5_err_cleared", 64'(err_after_start), 64'd0);
    chk("t5_edge_wr_cnt", 64'(wr_cnt), 64'd1);
    chk("t5_edge_wr_gap", 64'(wr_c[0] - vin_c[0]), 64'(TIMEOUT + 1));
    chk("t5_edge_err", 64'(err_at_done), 64'd0);

    // Reset during WAIT of chunk 1
    src_mem[0] = {$urandom, $urandom};
    src_mem[1] = {$urandom, $urandom};
    push_job(2);
    lat_cfg = 10;
    clear_mon();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_chunks = 3'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.num_chunks = '0;
    for (int k = 0; k < 100 && vin_cnt < 2; k++) begin
      @(posedge clk); #1;
    end
    chk("t6_reached_wait", 64'(vin_cnt >= 2), 64'd1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_strobes", 64'({bus.busy, bus.done, bus.err, bus.rd_en, bus.pfx_valid_in, bus.wr_en}), 64'd0);
    chk("t6_rst_addr", 64'({bus.rd_addr, bus.wr_addr}), 64'd0);
    chk("t6_rst_ivec", bus.pfx_ivec, 64'd0);
    chk("t6_rst_wdata", bus.wr_data, 64'd0);
    chk("t6_pending", 64'(exp_addr.size()), 64'd1);
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("t6_late_no_wr", 64'(wr_cnt), 64'(w0));
    chk("t6_idle", 64'(bus.busy), 64'd0);
    src_mem[0] = {$urandom, $urandom};
    push_job(1);
    run_job(1, 2, 0, t);
    chk("t6_fresh_wd", last_wd, lpfx(src_mem[0]));

    // Random latency, random data, count above capacity clamps to 4
    for (int i = 0; i < 4; i++) src_mem[i] = {$urandom, $urandom};
    push_job(4);
    run_job(7, -1, 0, t);
    chk("t7_vin_cnt", 64'(vin_cnt), 64'd4);
    chk("t7_rd_cnt", 64'(rd_cnt), 64'd4);
    chk("t7_wr_cnt", 64'(wr_cnt), 64'd4);
    chk("t7_err", 64'(err_at_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
